// File: rtl/sim_run_monitor.sv
// Run monitor for simulation: global cycle timeout, per-channel heartbeat watchdog
// and pass/fail capture, latched as a sticky DONE result until clr or reset.
module sim_run_monitor #(
    parameter int CNT_W      = 32,
    parameter int NCH        = 4,
    parameter int MAX_CYCLES = 30000000,
    parameter int HB_LIMIT   = 4096
) (
    input  logic             i_ext_pad_clkmux_ehs_clk,
    input  logic             PI_SOC_RST_B,
    input  logic             enable,
    input  logic             clr,
    input  logic [NCH-1:0]   ch_mask,
    input  logic [NCH-1:0]   hb_evt,
    input  logic             pass_req,
    input  logic             fail_req,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [1:0]       state,
    output logic             done,
    output logic [1:0]       result,
    output logic [NCH-1:0]   hang_ch
);

    // state | meaning
    // IDLE  | counters held at 0, waiting for enable
    // RUN   | counting (enable=1) or paused (enable=0), watching for end events
    // DONE  | result latched, all run inputs ignored until clr
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [1:0]       RES_NONE = 2'b00;
    localparam logic [1:0]       RES_PASS = 2'b01;
    localparam logic [1:0]       RES_FAIL = 2'b10;
    localparam logic [1:0]       RES_HANG = 2'b11;
    localparam logic [CNT_W-1:0] CYC_TC   = CNT_W'(MAX_CYCLES - 1);
    localparam logic [15:0]      HB_TC    = 16'(HB_LIMIT - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             res_q, res_d;
    logic [NCH-1:0]         hang_q, hang_d;
    logic [NCH-1:0][15:0]   idle_q, idle_d;
    logic [NCH-1:0]         hb_hit;

    always_ff @(posedge i_ext_pad_clkmux_ehs_clk or posedge PI_SOC_RST_B) begin
        if (PI_SOC_RST_B) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= RES_NONE;
            hang_q  <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            hang_q  <= hang_d;
            idle_q  <= idle_d;
        end
    end

    // A channel is hung when its idle counter is at terminal count and no heartbeat rescues it.
    always_comb begin
        hb_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            hb_hit[i] = ch_mask[i] && !hb_evt[i] && (idle_q[i] == HB_TC);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        hang_d  = hang_q;
        idle_d  = idle_q;
        if (clr) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            res_d   = RES_NONE;
            hang_d  = '0;
            idle_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d  = '0;
                    res_d  = RES_NONE;
                    hang_d = '0;
                    idle_d = '0;
                    if (enable) state_d = S_RUN;
                end
                S_RUN: begin
                    if (fail_req) begin
                        state_d = S_DONE;
                        res_d   = RES_FAIL;
                    end else if (pass_req) begin
                        state_d = S_DONE;
                        res_d   = RES_PASS;
                    end else if (enable) begin
                        if (|hb_hit) begin
                            state_d = S_DONE;
                            res_d   = RES_HANG;
                            hang_d  = hb_hit;
                        end else if (cnt_q == CYC_TC) begin
                            state_d = S_DONE;
                            res_d   = RES_HANG;
                            hang_d  = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                            for (int i = 0; i < NCH; i++) begin
                                idle_d[i] = (ch_mask[i] && !hb_evt[i]) ? idle_q[i] + 16'd1 : 16'd0;
                            end
                        end
                    end
                end
                S_DONE: begin
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    res_d   = RES_NONE;
                    hang_d  = '0;
                    idle_d  = '0;
                end
            endcase
        end
    end

    assign cycle_cnt = cnt_q;
    assign state     = state_q;
    assign done      = (state_q == S_DONE);
    assign result    = res_q;
    assign hang_ch   = hang_q;

endmodule

// File: tb/tb_sim_run_monitor.sv
// Directed bench for sim_run_monitor (NCH=2, MAX_CYCLES=100, HB_LIMIT=8) with a
// cycle-level reference model compared every negedge plus literal end-of-scenario checks.
module tb_sim_run_monitor;
    localparam int NCH  = 2;
    localparam int MAXC = 100;
    localparam int HBL  = 8;
    localparam int CW   = 32;

    logic clk = 1'b0, rst = 1'b0, en = 1'b0, clr = 1'b0, pass = 1'b0, fail = 1'b0;
    logic [NCH-1:0] mask = '0, hb = '0;
    logic [CW-1:0]  cycle_cnt;
    logic [1:0]     state, result;
    logic           done;
    logic [NCH-1:0] hang_ch;

    int total = 0, bad = 0;
    bit cmp_on = 1'b0;

    sim_run_monitor #(.CNT_W(CW), .NCH(NCH), .MAX_CYCLES(MAXC), .HB_LIMIT(HBL)) dut (
        .i_ext_pad_clkmux_ehs_clk(clk),
        .PI_SOC_RST_B(rst),
        .enable(en),
        .clr(clr),
        .ch_mask(mask),
        .hb_evt(hb),
        .pass_req(pass),
        .fail_req(fail),
        .cycle_cnt(cycle_cnt),
        .state(state),
        .done(done),
        .result(result),
        .hang_ch(hang_ch)
    );

    always #5 clk = ~clk;

    // Model: run phase 0/1/2, active-cycle count, and per-channel "last quiet point";
    // idle time of a channel is simply m_act - m_last[i].
    int             m_st, m_act, m_res;
    int             m_last [NCH];
    logic [NCH-1:0] m_hang;

    always @(posedge clk or posedge rst) begin : model
        logic [NCH-1:0] hung;
        if (rst || clr) begin
            m_st = 0; m_act = 0; m_res = 0; m_hang = '0;
            for (int i = 0; i < NCH; i++) m_last[i] = 0;
        end else if (m_st == 0) begin
            if (en) m_st = 1;
        end else if (m_st == 1) begin
            hung = '0;
            for (int i = 0; i < NCH; i++)
                if (mask[i] && !hb[i] && (m_act - m_last[i] == HBL - 1)) hung[i] = 1'b1;
            if (fail) begin
                m_st = 2; m_res = 2;
            end else if (pass) begin
                m_st = 2; m_res = 1;
            end else if (en && hung != 0) begin
                m_st = 2; m_res = 3; m_hang = hung;
            end else if (en && m_act == MAXC - 1) begin
                m_st = 2; m_res = 3; m_hang = '0;
            end else if (en) begin
                for (int i = 0; i < NCH; i++)
                    if (!mask[i] || hb[i]) m_last[i] = m_act + 1;
                m_act++;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            total++;
            if ({state, done, result, hang_ch, cycle_cnt} !==
                {2'(m_st), 1'(m_st == 2), 2'(m_res), m_hang, CW'(m_act)}) begin
                bad++;
                $display("FAIL model_cmp t=%0t actual st=%0d done=%0b res=%0d hang=%b cnt=%0d required st=%0d res=%0d hang=%b cnt=%0d",
                         $time, state, done, result, hang_ch, cycle_cnt, m_st, m_res, m_hang, m_act);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            cyc(1);
            n++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s done=%0b required=1 within %0d cycles", name, done, budget);
        end
    endtask

    task automatic idle_inputs();
        en = 0; pass = 0; fail = 0; hb = '0; mask = '0;
    endtask

    task automatic do_clr();
        clr = 1; cyc(1); clr = 0;
    endtask

    initial begin
        #1 rst = 1;
        #2;
        cmp_on = 1;
        chk("rst_state", state, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", cycle_cnt, 0);
        chk("rst_result", result, 0);
        cyc(2);
        rst = 0;
        cyc(1);

        // global timeout with nothing watched
        en = 1; cyc(1);
        chk("run_entry_state", state, 1);
        chk("run_entry_cnt", cycle_cnt, 0);
        wait_done(200, "timeout_wait");
        chk("timeout_cnt", cycle_cnt, 99);
        chk("timeout_result", result, 3);
        chk("timeout_hang", hang_ch, 0);
        pass = 1; fail = 1; hb = 2'b11; mask = 2'b11; cyc(3);
        chk("done_hold_cnt", cycle_cnt, 99);
        chk("done_hold_result", result, 3);
        idle_inputs(); do_clr();
        chk("clr_state", state, 0);
        chk("clr_done", done, 0);
        chk("clr_cnt", cycle_cnt, 0);

        // pass with a live channel
        mask = 2'b01; en = 1; cyc(1);
        for (int k = 0; k <= 40; k++) begin
            hb = {1'b0, (k % 5 == 4)};
            pass = (k == 40);
            cyc(1);
        end
        chk("pass_result", result, 1);
        chk("pass_cnt", cycle_cnt, 40);
        chk("pass_hang", hang_ch, 0);
        idle_inputs(); do_clr();

        // channel 1 silent, channel 0 healthy
        mask = 2'b11; en = 1; cyc(1);
        for (int k = 0; k < 30; k++) begin
            hb = {1'b0, (k % 3 == 2)};
            cyc(1);
            if (done) break;
        end
        chk("hang1_result", result, 3);
        chk("hang1_cnt", cycle_cnt, 7);
        chk("hang1_ch", hang_ch, 2'b10);
        idle_inputs(); do_clr();

        // both channels silent
        mask = 2'b11; en = 1; cyc(1);
        wait_done(30, "hang_both_wait");
        chk("hang_both_ch", hang_ch, 2'b11);
        chk("hang_both_cnt", cycle_cnt, 7);
        idle_inputs(); do_clr();

        // heartbeat exactly at terminal count rescues the channel
        mask = 2'b10; en = 1; cyc(1);
        for (int k = 0; k < 40; k++) begin
            hb = {(k == 7), 1'b0};
            cyc(1);
            if (done) break;
        end
        chk("rescue_cnt", cycle_cnt, 15);
        chk("rescue_ch", hang_ch, 2'b10);
        idle_inputs(); do_clr();

        // pause then simultaneous fail+pass
        en = 1; cyc(1);
        for (int k = 0; k <= 10; k++) begin
            en = !(k >= 3 && k <= 6);
            pass = (k == 10);
            fail = (k == 10);
            cyc(1);
            if (k == 5) chk("pause_cnt", cycle_cnt, 3);
        end
        chk("fail_prio_result", result, 2);
        chk("fail_prio_cnt", cycle_cnt, 6);
        idle_inputs(); do_clr();

        // long pause with silent channels: no hang, pass still honoured
        mask = 2'b11; en = 1; cyc(1); cyc(5);
        en = 0; cyc(10);
        chk("pause_nohang_state", state, 1);
        chk("pause_nohang_cnt", cycle_cnt, 5);
        pass = 1; cyc(1); pass = 0;
        chk("pause_pass_result", result, 1);
        idle_inputs(); do_clr();

        // clr wins over enable in IDLE and over pass in RUN
        en = 1; clr = 1; cyc(1); clr = 0; en = 0;
        chk("clr_vs_en_state", state, 0);
        en = 1; cyc(1); cyc(3);
        chk("pre_clr_cnt", cycle_cnt, 3);
        pass = 1; clr = 1; cyc(1); pass = 0; clr = 0;
        chk("clr_pass_state", state, 0);
        chk("clr_pass_result", result, 0);
        chk("clr_pass_cnt", cycle_cnt, 0);

        // async reset mid-RUN, then in DONE
        cyc(1); cyc(4);
        #2 rst = 1;
        #1;
        chk("arst_run_state", state, 0);
        chk("arst_run_cnt", cycle_cnt, 0);
        @(posedge clk); #1 rst = 0;
        cyc(1);
        chk("post_rst_state", state, 1);
        chk("post_rst_cnt", cycle_cnt, 0);
        fail = 1; cyc(1); fail = 0;
        chk("pre_rst_result", result, 2);
        #2 rst = 1;
        #1;
        chk("arst_done_result", result, 0);
        chk("arst_done_done", done, 0);
        @(posedge clk); #1 rst = 0;
        idle_inputs(); cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end
endmodule
